// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
// Module  : csa_pkg
// Brief   : Shared types and helpers for the carry-save resolver.
// Revision: 1.0 - initial release
// ============================================================================
package csa_pkg;

  // Resolver sequencing states.
  typedef enum logic [1:0] {
    CSA_IDLE = 2'd0,
    CSA_BUSY = 2'd1,
    CSA_DONE = 2'd2
  } csa_res_state_e;

  // Number of CHUNK-wide slices needed to cover 'width' bits (ceiling division).
  function automatic int csa_nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csa_chunk_add.sv
`default_nettype none
// ============================================================================
// Module  : csa_chunk_add
// Brief   : Combinational CHUNK-bit adder with carry in and carry out.
// Revision: 1.0 - initial release
// ============================================================================
module csa_chunk_add #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o
);

  // One extra bit on the left captures the carry out of the slice.
  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule
`default_nettype wire

// File: rtl/csa_resolve_seq.sv
`default_nettype none
// ============================================================================
// Module  : csa_resolve_seq
// Brief   : Resolves a carry-save pair to binary (sum + (carry << 1)) with a
//           multi-cycle chunked carry-propagate adder, one op in flight.
// Revision: 1.0 - initial release
// ============================================================================
module csa_resolve_seq
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result,
  output logic             busy
);

  localparam int RW     = WIDTH + 2;
  localparam int NCHUNK = csa_nchunk(RW, CHUNK);
  localparam int EW     = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NCHUNK - 1);

  csa_res_state_e  state_q, state_d;
  logic [EW-1:0]   a_q, b_q, res_q;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;

  logic            w_accept;
  logic [31:0]     w_base;
  logic [CHUNK-1:0] w_a, w_b, w_s;
  logic            w_cout;

  assign w_accept = in_valid && (state_q == CSA_IDLE);
  assign w_base   = 32'(int'(cnt_q) * CHUNK);
  assign w_a      = a_q[w_base +: CHUNK];
  assign w_b      = b_q[w_base +: CHUNK];

  csa_chunk_add #(
    .CHUNK (CHUNK)
  ) u_add (
    .a_i    (w_a),
    .b_i    (w_b),
    .cin_i  (carry_q),
    .s_o    (w_s),
    .cout_o (w_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CSA_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, step chunks in BUSY, wait for sink in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CSA_IDLE: if (w_accept)        state_d = CSA_BUSY;
      CSA_BUSY: if (cnt_q == C_LAST) state_d = CSA_DONE;
      CSA_DONE: if (out_ready)       state_d = CSA_IDLE;
      default:                       state_d = CSA_IDLE;
    endcase
  end

  // Operand capture on accept, then one chunk of the CPA per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (w_accept) begin
      // Carry vector is pre-shifted so both operands share bit weights.
      a_q     <= EW'(sum_in);
      b_q     <= EW'({carry_in, 1'b0});
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (state_q == CSA_BUSY) begin
      res_q[w_base +: CHUNK] <= w_s;
      carry_q                <= w_cout;
      cnt_q                  <= (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Padding bits above RW are always zero-sum and never leave the block.
  generate
    if (EW > RW) begin : g_pad
      logic w_unused_pad;
      assign w_unused_pad = ^res_q[EW-1:RW];
    end
  endgenerate

  assign in_ready  = (state_q == CSA_IDLE);
  assign out_valid = (state_q == CSA_DONE);
  assign busy      = (state_q != CSA_IDLE);
  assign result    = res_q[RW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_csa_resolve_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_csa_resolve_seq
// Brief   : Self-checking bench for csa_resolve_seq in three CHUNK configs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_csa_resolve_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] sum_in    [3];
  logic [31:0] carry_in  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [33:0] result    [3];
  logic        busy      [3];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  csa_resolve_seq #(.WIDTH(32), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .sum_in(sum_in[0]), .carry_in(carry_in[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(result[0]), .busy(busy[0])
  );

  csa_resolve_seq #(.WIDTH(32), .CHUNK(34)) u_dut34 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .sum_in(sum_in[1]), .carry_in(carry_in[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(result[1]), .busy(busy[1])
  );

  csa_resolve_seq #(.WIDTH(32), .CHUNK(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .sum_in(sum_in[2]), .carry_in(carry_in[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .result(result[2]), .busy(busy[2])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int chunk_of(input int idx);
    return (idx == 0) ? 8 : (idx == 1) ? 34 : 5;
  endfunction

  // Reference: plain arithmetic value of the carry-save pair.
  function automatic logic [33:0] ref_value(input logic [31:0] s, input logic [31:0] c);
    logic [33:0] v;
    v = 34'(s) + (34'(c) * 34'd2);
    return v;
  endfunction

  // One operation on instance idx, with 'stall' cycles of out_ready low in DONE.
  task automatic run_op(input int idx, input logic [31:0] s, input logic [31:0] c,
                        input int stall, input bit pulse);
    logic [33:0] exp;
    int n;
    int lat;
    exp = ref_value(s, c);
    lat = (34 + chunk_of(idx) - 1) / chunk_of(idx);
    @(negedge clk);
    n = 0;
    while (!in_ready[idx] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_ready", 64'(in_ready[idx]), 64'd1);
    in_valid[idx] = 1'b1;
    sum_in[idx]   = s;
    carry_in[idx] = c;
    @(negedge clk);
    in_valid[idx] = 1'b0;
    chk("busy_after_accept", 64'(busy[idx]), 64'd1);
    n = 0;
    while (!out_valid[idx] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("result", 64'(result[idx]), 64'(exp));
    chk("ready_low_in_done", 64'(in_ready[idx]), 64'd0);
    for (int i = 0; i < stall; i++) begin
      out_ready[idx] = 1'b0;
      if (pulse) begin
        in_valid[idx] = 1'b1;
        sum_in[idx]   = $urandom;
        carry_in[idx] = $urandom;
      end
      @(negedge clk);
      chk("stall_result", 64'(result[idx]), 64'(exp));
      chk("stall_valid", 64'(out_valid[idx]), 64'd1);
      chk("stall_ready", 64'(in_ready[idx]), 64'd0);
    end
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b1;
    @(negedge clk);
    out_ready[idx] = 1'b0;
    chk("post_hs_valid", 64'(out_valid[idx]), 64'd0);
    chk("post_hs_ready", 64'(in_ready[idx]), 64'd1);
    chk("post_hs_hold", 64'(result[idx]), 64'(exp));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      sum_in[i]    = '0;
      carry_in[i]  = '0;
      out_ready[i] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", 64'(in_ready[i]), 64'd1);
      chk("rst_valid", 64'(out_valid[i]), 64'd0);
      chk("rst_busy", 64'(busy[i]), 64'd0);
      chk("rst_result", 64'(result[i]), 64'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // All-ones operands and a long ripple across chunk boundaries.
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(0, 32'h0000_FFFF, 32'h0000_0001, 0, 1'b0);

    // Backpressure with spurious in_valid pulses.
    run_op(0, 32'h1234_5678, 32'h0F0F_0F0F, 10, 1'b1);

    // Back-to-back with in_valid held and out_ready high.
    @(negedge clk);
    in_valid[0]  = 1'b1;
    sum_in[0]    = 32'd1;
    carry_in[0]  = 32'd0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    sum_in[0]    = 32'd0;
    carry_in[0]  = 32'd1;
    chk("b2b_busy1", 64'(busy[0]), 64'd1);
    n = 0;
    while (!out_valid[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_lat1", 64'(n), 64'd5);
    chk("b2b_res1", 64'(result[0]), 64'd1);
    @(negedge clk);
    chk("b2b_gap_ready", 64'(in_ready[0]), 64'd1);
    chk("b2b_gap_valid", 64'(out_valid[0]), 64'd0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("b2b_accept2", 64'(busy[0]), 64'd1);
    n = 0;
    while (!out_valid[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_lat2", 64'(n), 64'd5);
    chk("b2b_res2", 64'(result[0]), 64'd2);
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk("b2b_done_ready", 64'(in_ready[0]), 64'd1);

    // Reset in the middle of BUSY.
    in_valid[0] = 1'b1;
    sum_in[0]   = 32'hDEAD_BEEF;
    carry_in[0] = 32'h0BAD_F00D;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid[0]), 64'd0);
    chk("midrst_ready", 64'(in_ready[0]), 64'd1);
    chk("midrst_busy", 64'(busy[0]), 64'd0);
    chk("midrst_result", 64'(result[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 32'd5, 32'd3, 0, 1'b0);

    // Other chunk configurations.
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);

    // Randomized operands and stalls.
    for (int i = 0; i < 30; i++)
      run_op(0, $urandom, $urandom, int'($urandom_range(0, 3)), 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_op(1, $urandom, $urandom, int'($urandom_range(0, 2)), 1'b0);
      run_op(2, $urandom, $urandom, int'($urandom_range(0, 2)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
